// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RISCV-Lite MEM stage: load/store sequencing over req/gnt/rvalid, forwarding and WB result.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_alu_res,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    output logic              stall,
    output logic [XLEN-1:0]   mem_fwd_data,
    output logic [4:0]        mem_fwd_rd,
    output logic              mem_fwd_we,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_reg_write,
    output logic              misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R} state_t;

    state_t            r_state;
    logic              r_is_load;
    logic [1:0]        r_lane;
    logic [2:0]        r_funct3;
    logic              r_reg_write;
    logic              r_gnt_pend;
    logic              r_rv_pend;
    logic [XLEN-1:0]   r_rdata_pend;

    logic [XLEN-1:0]   r_fwd_data;
    logic [4:0]        r_fwd_rd;
    logic              r_fwd_we;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [XLEN-1:0]   r_dmem_wdata;
    logic [3:0]        r_dmem_be;
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [XLEN-1:0]   r_wb_data;
    logic              r_wb_reg_write;
    logic              r_misalign;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_misalign;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic              w_gnt;
    logic              w_rvalid;
    logic [XLEN-1:0]   w_rdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load_data;

    assign stall      = (r_state != S_IDLE);
    assign w_accept   = EN & ex_valid & (r_state == S_IDLE);
    assign w_is_mem   = ex_mem_read | ex_mem_write;
    // funct3[1:0]: 00 byte, 01 half, 1x word (unknown encodings behave as word)
    assign w_misalign = ((ex_funct3[1:0] == 2'b01) & ex_alu_res[0]) |
                        (ex_funct3[1] & (ex_alu_res[1:0] != 2'b00));

    // A gnt/rvalid seen while EN was low is replayed from the pending flags
    assign w_gnt    = dmem_gnt | r_gnt_pend;
    assign w_rvalid = dmem_rvalid | r_rv_pend;
    assign w_rdata  = r_rv_pend ? r_rdata_pend : dmem_rdata;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ex_alu_res[1:0];
                w_wdata = {(XLEN/8){ex_store_data[7:0]}};
            end
            2'b01: begin
                w_be    = ex_alu_res[1] ? 4'b1100 : 4'b0011;
                w_wdata = {(XLEN/16){ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte      = w_rdata[{r_lane, 3'b000} +: 8];
        w_half      = r_lane[1] ? w_rdata[31:16] : w_rdata[15:0];
        w_load_data = w_rdata;
        case (r_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = w_rdata;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state        <= S_IDLE;
            r_is_load      <= 1'b0;
            r_lane         <= 2'b00;
            r_funct3       <= 3'b000;
            r_reg_write    <= 1'b0;
            r_gnt_pend     <= 1'b0;
            r_rv_pend      <= 1'b0;
            r_rdata_pend   <= '0;
            r_fwd_data     <= '0;
            r_fwd_rd       <= 5'd0;
            r_fwd_we       <= 1'b0;
            r_dmem_req     <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= '0;
            r_dmem_wdata   <= '0;
            r_dmem_be      <= 4'b0000;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_data      <= '0;
            r_wb_reg_write <= 1'b0;
            r_misalign     <= 1'b0;
        end else if (!EN) begin
            // Frozen, but the memory keeps talking: capture its responses once granted
            if (r_state == S_REQ && dmem_gnt && !r_gnt_pend) begin
                r_gnt_pend <= 1'b1;
                r_dmem_req <= 1'b0;
            end
            if (dmem_rvalid && !r_rv_pend &&
                (r_state == S_WAIT_R || (r_state == S_REQ && r_gnt_pend))) begin
                r_rv_pend    <= 1'b1;
                r_rdata_pend <= dmem_rdata;
            end
        end else begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_misalign     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_fwd_we <= 1'b0;
                    if (w_accept) begin
                        r_fwd_data  <= ex_alu_res;
                        r_fwd_rd    <= ex_rd;
                        r_fwd_we    <= ex_reg_write & ~w_is_mem;
                        r_wb_rd     <= ex_rd;
                        r_wb_data   <= ex_alu_res;
                        r_lane      <= ex_alu_res[1:0];
                        r_funct3    <= ex_funct3;
                        r_reg_write <= ex_reg_write;
                        r_is_load   <= ex_mem_read & ~ex_mem_write;
                        if (!w_is_mem) begin
                            r_wb_valid     <= 1'b1;
                            r_wb_reg_write <= ex_reg_write;
                        end else if (w_misalign) begin
                            r_wb_valid <= 1'b1;
                            r_misalign <= 1'b1;
                        end else begin
                            r_state      <= S_REQ;
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= ex_mem_write;
                            r_dmem_addr  <= {ex_alu_res[ADDR_W-1:2], 2'b00};
                            r_dmem_be    <= w_be;
                            r_dmem_wdata <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (w_gnt) begin
                        r_gnt_pend <= 1'b0;
                        r_dmem_req <= 1'b0;
                        if (r_is_load) begin
                            r_state <= S_WAIT_R;
                        end else begin
                            r_state    <= S_IDLE;
                            r_wb_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT_R: begin
                    if (w_rvalid) begin
                        r_rv_pend      <= 1'b0;
                        r_state        <= S_IDLE;
                        r_wb_valid     <= 1'b1;
                        r_wb_data      <= w_load_data;
                        r_wb_reg_write <= r_reg_write;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_fwd_data = r_fwd_data;
    assign mem_fwd_rd   = r_fwd_rd;
    assign mem_fwd_we   = r_fwd_we;
    assign dmem_req     = r_dmem_req;
    assign dmem_we      = r_dmem_we;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_wdata   = r_dmem_wdata;
    assign dmem_be      = r_dmem_be;
    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign wb_reg_write = r_wb_reg_write;
    assign misalign     = r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - Self-checking bench for mem_access_unit against a behavioural memory-access model.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        EN;
    logic        ex_valid;
    logic [31:0] ex_alu_res;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        stall;
    logic [31:0] mem_fwd_data;
    logic [4:0]  mem_fwd_rd;
    logic        mem_fwd_we;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mem_access_unit #(.ADDR_W(32), .XLEN(32)) dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN),
        .ex_valid(ex_valid), .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .stall(stall), .mem_fwd_data(mem_fwd_data), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_we(mem_fwd_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
        .misalign(misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge CLK);
    endtask

    // Reference model: access size in bytes, from the RISC-V funct3 rules
    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_be(input int size, input int off);
        if (size == 1) return 4'(1 << off);
        if (size == 2) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input int size, input logic [31:0] d);
        if (size == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (size == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
        int    size;
        longint v;
        size = acc_size(f3);
        if (size == 4) return rd;
        v = longint'((rd >> (8 * off)) & 32'((64'd1 << (8 * size)) - 1));
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= longint'(64'd1 << (8 * size - 1)))
            v = v - longint'(64'd1 << (8 * size));
        return v[31:0];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_fwd"}, {mem_fwd_data[26:0], mem_fwd_rd}, 0);
        chk({tag, "_fwd_hi"}, {27'd0, mem_fwd_data[31:27]}, 0);
        chk({tag, "_ctl"}, {mem_fwd_we, dmem_req, dmem_we, wb_valid, wb_reg_write, misalign}, 0);
        chk({tag, "_addr"}, dmem_addr, 0);
        chk({tag, "_wdata"}, dmem_wdata, 0);
        chk({tag, "_be_rd"}, {dmem_be, wb_rd}, 0);
        chk({tag, "_wbdata"}, wb_data, 0);
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] res, input bit rw);
        ex_valid = 1'b1; ex_alu_res = res; ex_rd = rd; ex_reg_write = rw;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = 3'($urandom); ex_store_data = $urandom;
        nxt();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_data", wb_data, res);
        chk("alu_wb_rd", wb_rd, rd);
        chk("alu_wb_rw", wb_reg_write, rw);
        chk("alu_fwd_we", mem_fwd_we, rw);
        chk("alu_fwd_data", mem_fwd_data, res);
        chk("alu_fwd_rd", mem_fwd_rd, rd);
        chk("alu_stall", stall, 0);
        chk("alu_quiet", {misalign, dmem_req}, 0);
    endtask

    task automatic mem_op(input bit st, input bit both, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd, input bit rw,
                          input int g, input int r, input logic [31:0] rdata);
        int size, off, stalls;
        size = acc_size(f3);
        off  = int'(addr[1:0]);
        ex_valid = 1'b1; ex_alu_res = addr; ex_store_data = data; ex_rd = rd; ex_funct3 = f3;
        ex_mem_write = st; ex_mem_read = st ? both : 1'b1; ex_reg_write = rw;
        nxt();
        ex_valid = 1'b0;
        if ((off % size) != 0) begin
            chk("mis_pulse", misalign, 1);
            chk("mis_wb_valid", wb_valid, 1);
            chk("mis_wb_rw", wb_reg_write, 0);
            chk("mis_no_req", dmem_req, 0);
            chk("mis_stall", stall, 0);
            nxt();
            chk("mis_clear", {misalign, wb_valid}, 0);
            return;
        end
        stalls = 0;
        for (int k = 0; k <= g; k++) begin
            chk("req", dmem_req, 1);
            chk("req_addr", dmem_addr, addr & ~32'd3);
            chk("req_we", dmem_we, st);
            chk("req_be", dmem_be, exp_be(size, off));
            if (st) chk("req_wdata", dmem_wdata, exp_wdata(size, data));
            chk("req_fwd_we", mem_fwd_we, 0);
            chk("req_wb_idle", wb_valid, 0);
            stalls += int'(stall);
            dmem_gnt = (k == g);
            nxt();
        end
        dmem_gnt = 1'b0;
        if (!st) begin
            for (int j = 1; j <= r; j++) begin
                chk("wait_req_low", dmem_req, 0);
                chk("wait_wb_idle", wb_valid, 0);
                stalls += int'(stall);
                if (j == r) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                end
                nxt();
            end
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            chk("ld_data", wb_data, exp_load(f3, off, rdata));
            chk("ld_rw", wb_reg_write, rw);
            chk("ld_rd", wb_rd, rd);
        end else begin
            chk("st_rw", wb_reg_write, 0);
        end
        chk("done_wb_valid", wb_valid, 1);
        chk("done_stall", stall, 0);
        chk("stall_cycles", stalls, st ? g + 1 : g + 1 + r);
        nxt();
        chk("wb_pulse_end", wb_valid, 0);
    endtask

    initial begin
        logic [2:0]  ld_f3 [8];
        logic [2:0]  st_f3 [3];
        logic [31:0] d;
        int          seen;
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        st_f3 = '{3'b000, 3'b001, 3'b010};

        RSTn = 1'b0; EN = 1'b1; ex_valid = 1'b0; ex_alu_res = '0; ex_store_data = '0;
        ex_rd = '0; ex_funct3 = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        nxt(); nxt();
        chk_all_zero("reset");
        RSTn = 1'b1;
        nxt();

        alu_op(5'd5, 32'h0000_1234, 1'b1);
        ex_valid = 1'b0;
        nxt();
        chk("alu_pulse_end", wb_valid, 0);

        mem_op(1'b0, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 0, 2, 32'h80FF_FF00);
        mem_op(1'b0, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd8, 1'b1, 1, 1, 32'h8001_1234);
        mem_op(1'b0, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 0, 1, 32'h8001_1234);
        mem_op(1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd0, 1'b0, 3, 0, 32'h0);
        mem_op(1'b0, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd10, 1'b1, 0, 1, 32'h0);
        mem_op(1'b1, 1'b1, 3'b001, 32'h0000_0206, 32'hDEAD_BEEF, 5'd0, 1'b0, 1, 0, 32'h0);

        for (int i = 0; i < 8; i++)
            alu_op(5'($urandom_range(1, 31)), $urandom, 1'($urandom_range(0, 1)));
        ex_valid = 1'b0;

        alu_op(5'd3, 32'hCAFE_0001, 1'b1);
        ex_valid = 1'b0; EN = 1'b0;
        nxt();
        chk("en_hold_wb_valid", wb_valid, 1);
        chk("en_hold_wb_data", wb_data, 32'hCAFE_0001);
        EN = 1'b1;
        nxt();
        chk("en_resume_pulse_end", wb_valid, 0);

        d = $urandom;
        ex_valid = 1'b1; ex_alu_res = 32'h300; ex_rd = 5'd11; ex_funct3 = 3'b010;
        ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
        nxt();
        ex_valid = 1'b0;
        chk("en_req", dmem_req, 1);
        EN = 1'b0; dmem_gnt = 1'b1;
        nxt();
        dmem_gnt = 1'b0;
        chk("en_low_stall", stall, 1);
        chk("en_low_wb", wb_valid, 0);
        dmem_rvalid = 1'b1; dmem_rdata = d;
        nxt();
        dmem_rvalid = 1'b0; dmem_rdata = ~d; EN = 1'b1;
        seen = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            nxt();
            if (wb_valid) seen = 1;
        end
        chk("en_latched_done", seen, 1);
        chk("en_latched_data", wb_data, d);
        chk("en_latched_rd", wb_rd, 11);
        nxt();

        ex_valid = 1'b1; ex_alu_res = 32'h400; ex_rd = 5'd12; ex_funct3 = 3'b010;
        ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
        nxt();
        ex_valid = 1'b0; dmem_gnt = 1'b1;
        nxt();
        dmem_gnt = 1'b0;
        chk("rst_wait_stall", stall, 1);
        RSTn = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        nxt();
        RSTn = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        nxt();
        dmem_rvalid = 1'b0;
        chk("rst_stale_rvalid", {wb_valid, stall}, 0);
        nxt();
        chk("rst_stale_rvalid2", wb_valid, 0);
        alu_op(5'd13, 32'h0BAD_F00D, 1'b1);
        ex_valid = 1'b0;
        nxt();

        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = 32'h1000 + 32'($urandom_range(0, 255));
            if (kind == 0) begin
                alu_op(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
                ex_valid = 1'b0;
            end else if (kind == 1) begin
                mem_op(1'b0, 1'b0, ld_f3[$urandom_range(0, 7)], a, $urandom,
                       5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
            end else begin
                mem_op(1'b1, ($urandom_range(0, 3) == 0), st_f3[$urandom_range(0, 2)], a, $urandom,
                       5'($urandom_range(0, 31)), 1'b0, $urandom_range(0, 3), 0, 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM stage of the RISCV-Lite pipeline; it is the consumer of the EX/MEM results: ALU result, store data, destination register and control bits.
- Performs loads and stores over a req/gnt/rvalid data-memory handshake and stalls the upstream pipeline while an access is outstanding.
- Drives the registered MEM-stage ALU result back to the EX forwarding muxes and presents aligned, extended load data to the WB stage.

Parameters:
- ADDR_W, 32, data-memory address width.
- XLEN, 32, data width.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- EN  in  1  global advance enable; when low, all state and outputs hold.
- ex_valid  in  1  EX/MEM slot holds a valid instruction.
- ex_alu_res  in  32  ALU result, which is the address for loads and stores.
- ex_store_data  in  32  forwarded rs2 value.
- ex_rd  in  5  destination register.
- ex_funct3  in  3  access size and sign selection.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_reg_write  in  1  writes the register file.
- stall  out  1  upstream must hold EX/MEM inputs stable.
- mem_fwd_data  out  32  registered ALU result for EX forwarding.
- mem_fwd_rd  out  5  rd of the instruction currently in MEM.
- mem_fwd_we  out  1  MEM instruction writes rd and is not a load.
- dmem_req  out  1  access request.
- dmem_we  out  1  write access.
- dmem_addr  out  ADDR_W  word-aligned address, {addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle pulse; result ready for WB.
- wb_rd  out  5  destination register.
- wb_data  out  32  ALU result or extended load data.
- wb_reg_write  out  1  commit to register file.
- misalign  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE.
- FSM states: IDLE, REQ, WAIT_R.
- Acceptance: an instruction is accepted at a rising edge when EN & ex_valid & !stall. At that edge the unit registers addr, data, rd, funct3 and control.
- Non-memory op:
  - wb_valid=1 in the cycle after acceptance, with wb_data = ALU result and wb_reg_write = ex_reg_write.
  - mem_fwd_* are valid in that same cycle.
  - Throughput is 1 per cycle.
- Load or store, aligned: FSM goes IDLE->REQ on acceptance.
  - In REQ: dmem_req=1. dmem_addr, dmem_we, dmem_be and dmem_wdata are held stable until dmem_gnt.
  - Store: on gnt, FSM goes REQ->IDLE and emits a wb_valid pulse with wb_reg_write=0.
  - Load: on gnt, FSM goes REQ->WAIT_R. On dmem_rvalid, FSM goes WAIT_R->IDLE, and wb_valid=1 the next cycle with the extended data.
  - rvalid in the same cycle as gnt is illegal; the memory guarantees it does not occur.
- stall = (state != IDLE); combinational from state.
  - The earliest completion for an access is 2 cycles after acceptance for a store and 3 cycles for a load.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
  - A misaligned access issues no dmem_req and stays in IDLE.
  - The next cycle it emits a misalign pulse plus wb_valid with wb_reg_write=0.
- Store lanes:
  - SB (000): be=1<<addr[1:0], wdata={4{data[7:0]}}.
  - SH (001): be=addr[1]?1100:0011, wdata={2{data[15:0]}}.
  - SW (010): be=1111, wdata=data.
- Load extraction: select the byte or half at addr[1:0] of dmem_rdata.
  - LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend; LW (010) passes the full word.
  - Other funct3 values are treated as LW.
- mem_fwd_we=0 while the MEM instruction is a load; hazard logic handles load-use.
- EN low: the FSM, registers and wb_valid hold. dmem_req stays asserted if in REQ; a gnt or rvalid arriving while EN=0 is not lost and is latched for use on resume.
- Reset mid-access: returns to IDLE immediately and drops dmem_req. Any in-flight rvalid after reset is ignored.
- ex_mem_read and ex_mem_write both set: treated as a store.

Test Plan:
- ALU op: rd=5, res=0x0000_1234, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, mem_fwd_we=1, stall=0.
- LB from addr 0x103 with rdata=0x80FF_FF00, gnt at REQ cycle 1, rvalid 2 cycles later -> wb_data=0xFFFF_FF80; stall high for exactly 3 cycles.
- LHU from addr 0x102 with rdata=0x8001_1234 -> wb_data=0x0000_8001. LH on the same inputs -> 0xFFFF_8001.
- SB data 0xAB to addr 0x201, gnt delayed 4 cycles -> dmem_be=0010, dmem_wdata=0xABABABAB, dmem_addr=0x200 held stable all 4 cycles; wb_reg_write=0.
- LW from addr 0x102 -> no dmem_req, misalign pulse, wb_reg_write=0.
- Reset asserted in WAIT_R -> state IDLE and all outputs 0. A later rvalid produces no wb_valid, and a following ALU op completes normally.
